// File: rtl/softmax_result_collector.sv
// Captures one softmax output vector into a local register file and serves it back through a
// registered random-access read port once the full vector has arrived.
module softmax_result_collector #(
  parameter int unsigned DATA_SIZE      = 32,
  parameter int unsigned NUMBER_OF_DATA = 10,
  parameter int unsigned ADDR_WIDTH     = 4
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  data_valid_i,
  input  logic [DATA_SIZE-1:0]  data_i,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0]  rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  localparam logic [ADDR_WIDTH:0] CountLast = (ADDR_WIDTH + 1)'(NUMBER_OF_DATA - 1);
  localparam logic [ADDR_WIDTH:0] CountFull = (ADDR_WIDTH + 1)'(NUMBER_OF_DATA);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_SIZE-1:0]  rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [DATA_SIZE-1:0]  mem_q [NUMBER_OF_DATA];
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  rd_addr_ok;

  assign wr_idx     = count_q[ADDR_WIDTH-1:0];
  assign rd_addr_ok = ({1'b0, rd_addr_i} < CountFull);

  // Capture FSM; start_i always wins over a beat on the same edge.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          state_d    = StCapture;
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (data_valid_i) begin
          overflow_d = 1'b1;
        end
      end
      StCapture: begin
        if (start_i) begin
          count_d    = '0;
          overflow_d = 1'b0;
        end else if (data_valid_i && (count_q < CountFull)) begin
          wr_en   = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == CountLast) begin
            state_d = StDone;
          end
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  // Reads are only honoured while a complete vector is held.
  always_comb begin
    rd_valid_d = (state_q == StDone) && rd_req_i;
    rd_data_d  = rd_data_q;
    if (rd_valid_d) begin
      rd_data_d = rd_addr_ok ? mem_q[rd_addr_i] : '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Buffer contents deliberately survive reset.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= data_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign busy_o     = (state_q == StCapture);
  assign done_o     = (state_q == StDone);
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_softmax_result_collector.sv
// Directed bench for softmax_result_collector: capture, gaps, overflow, restart, reads, reset.
module tb_softmax_result_collector;

  logic        clock;
  logic        reset;
  logic        start;
  logic        data_valid;
  logic [31:0] data;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  count;
  logic        busy;
  logic        done;
  logic        overflow;

  int tests_run;
  int tests_failed;

  logic [31:0] w  [10];
  logic [31:0] nw [10];

  softmax_result_collector #(
    .DATA_SIZE     (32),
    .NUMBER_OF_DATA(10),
    .ADDR_WIDTH    (4)
  ) dut (
    .clock_i     (clock),
    .reset_i     (reset),
    .start_i     (start),
    .data_valid_i(data_valid),
    .data_i      (data),
    .rd_req_i    (rd_req),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .count_o     (count),
    .busy_o      (busy),
    .done_o      (done),
    .overflow_o  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [31:0] word);
    data_valid = 1'b1;
    data       = word;
    step();
    data_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests_run++;
    if ({rd_data, rd_valid, count, busy, done, overflow} !== 41'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h v=%b cnt=%0d busy=%b done=%b ovf=%b, want all 0",
               rd_data, rd_valid, count, busy, done, overflow);
    end
  endtask

  task automatic read_all(input string name, input logic [31:0] exp_words [10]);
    for (int i = 0; i < 10; i++) begin
      rd_req  = 1'b1;
      rd_addr = 4'(i);
      step();
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== exp_words[i]) begin
        tests_failed++;
        $display("FAIL %s addr %0d: got v=%b data=%h, want v=1 data=%h",
                 name, i, rd_valid, rd_data, exp_words[i]);
      end
    end
    rd_req = 1'b0;
    step();
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== exp_words[9]) begin
      tests_failed++;
      $display("FAIL %s idle_hold: got v=%b data=%h, want v=0 data=%h",
               name, rd_valid, rd_data, exp_words[9]);
    end
  endtask

  task automatic test_contiguous();
    pulse_start();
    tests_run++;
    if (busy !== 1'b1 || count !== 5'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL contig_start: got busy=%b cnt=%0d done=%b, want busy=1 cnt=0 done=0",
               busy, count, done);
    end
    for (int i = 0; i < 10; i++) begin
      beat(w[i]);
      tests_run++;
      if (count !== 5'(i + 1) || done !== (i == 9) || busy !== (i != 9)) begin
        tests_failed++;
        $display("FAIL contig_beat %0d: got cnt=%0d done=%b busy=%b, want cnt=%0d done=%b busy=%b",
                 i, count, done, busy, i + 1, (i == 9), (i != 9));
      end
    end
    read_all("contig_read", w);
  endtask

  task automatic test_gaps();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < (i % 4); g++) step();
      tests_run++;
      if (done !== 1'b0 || count !== 5'(i)) begin
        tests_failed++;
        $display("FAIL gaps_hold %0d: got done=%b cnt=%0d, want done=0 cnt=%0d",
                 i, done, count, i);
      end
      beat(w[i]);
    end
    tests_run++;
    if (done !== 1'b1 || count !== 5'd10) begin
      tests_failed++;
      $display("FAIL gaps_done: got done=%b cnt=%0d, want done=1 cnt=10", done, count);
    end
    read_all("gaps_read", w);
  endtask

  task automatic test_overflow();
    beat(32'h12345678);
    tests_run++;
    if (overflow !== 1'b1 || done !== 1'b1 || count !== 5'd10) begin
      tests_failed++;
      $display("FAIL ovf_flag: got ovf=%b done=%b cnt=%0d, want ovf=1 done=1 cnt=10",
               overflow, done, count);
    end
    step();
    tests_run++;
    if (overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got ovf=%b, want 1", overflow);
    end
    rd_req  = 1'b1;
    rd_addr = 4'd9;
    step();
    rd_req  = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h3F9DF3B6) begin
      tests_failed++;
      $display("FAIL ovf_read9: got v=%b data=%h, want v=1 data=3f9df3b6", rd_valid, rd_data);
    end
  endtask

  task automatic test_restart();
    // Start with a simultaneous beat in DONE: start wins, overflow clears.
    start      = 1'b1;
    data_valid = 1'b1;
    data       = 32'hBAD0BAD0;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || busy !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL restart_done_start: got ovf=%b busy=%b cnt=%0d, want ovf=0 busy=1 cnt=0",
               overflow, busy, count);
    end
    for (int i = 0; i < 4; i++) beat(32'hDEAD0000 + 32'(i));
    tests_run++;
    if (count !== 5'd4) begin
      tests_failed++;
      $display("FAIL restart_partial: got cnt=%0d, want 4", count);
    end
    start      = 1'b1;
    data_valid = 1'b1;
    data       = 32'hBAD1BAD1;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
    tests_run++;
    if (count !== 5'd0 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_clear: got cnt=%0d busy=%b done=%b, want cnt=0 busy=1 done=0",
               count, busy, done);
    end
    for (int i = 0; i < 10; i++) beat(nw[i]);
    tests_run++;
    if (done !== 1'b1 || count !== 5'd10) begin
      tests_failed++;
      $display("FAIL restart_done: got done=%b cnt=%0d, want done=1 cnt=10", done, count);
    end
    read_all("restart_read", nw);
  endtask

  task automatic test_read_rules();
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      rd_req  = 1'b1;
      rd_addr = 4'(i);
      beat(w[i]);
      tests_run++;
      if (rd_valid !== 1'b0 || rd_data !== nw[9]) begin
        tests_failed++;
        $display("FAIL rd_in_capture %0d: got v=%b data=%h, want v=0 data=%h",
                 i, rd_valid, rd_data, nw[9]);
      end
    end
    rd_req = 1'b0;
    for (int i = 3; i < 10; i++) beat(w[i]);
    rd_req  = 1'b1;
    rd_addr = 4'd12;
    step();
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL rd_oob12: got v=%b data=%h, want v=1 data=0", rd_valid, rd_data);
    end
    rd_addr = 4'd4;
    step();
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== w[4]) begin
      tests_failed++;
      $display("FAIL rd_after_oob: got v=%b data=%h, want v=1 data=%h", rd_valid, rd_data, w[4]);
    end
    rd_addr = 4'd10;
    step();
    rd_req = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL rd_oob10: got v=%b data=%h, want v=1 data=0", rd_valid, rd_data);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    for (int i = 0; i < 5; i++) beat(nw[i]);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests_run++;
    if ({rd_data, rd_valid, count, busy, done, overflow} !== 41'd0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got data=%h v=%b cnt=%0d busy=%b done=%b ovf=%b, want 0",
               rd_data, rd_valid, count, busy, done, overflow);
    end
    beat(32'hCAFEF00D);
    beat(32'hCAFEF00E);
    tests_run++;
    if (overflow !== 1'b1 || count !== 5'd0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_overflow: got ovf=%b cnt=%0d busy=%b done=%b, want ovf=1 cnt=0 0 0",
               overflow, count, busy, done);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    start      = 1'b1;
    data_valid = 1'b1;
    data       = 32'hBAD2BAD2;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
    tests_run++;
    if (overflow !== 1'b0 || busy !== 1'b1 || count !== 5'd0) begin
      tests_failed++;
      $display("FAIL idle_start_beat: got ovf=%b busy=%b cnt=%0d, want ovf=0 busy=1 cnt=0",
               overflow, busy, count);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    w  = '{32'hC05060D2, 32'h40A5D0A4, 32'h3E4CCCCD, 32'h3DCCCCCD, 32'h3F000000,
           32'h3C23D70A, 32'h3F4CCCCD, 32'h3EAAAAAB, 32'h3D8F5C29, 32'h3F9DF3B6};
    for (int i = 0; i < 10; i++) nw[i] = 32'hA5A50000 + 32'(i) * 32'h111;
    reset      = 1'b0;
    start      = 1'b0;
    data_valid = 1'b0;
    data       = 32'd0;
    rd_req     = 1'b0;
    rd_addr    = 4'd0;

    test_reset();
    test_contiguous();
    test_gaps();
    test_overflow();
    test_restart();
    test_read_rules();
    test_mid_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
